jogador_automatico: RTL

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

---
 rtl/jogador_pkg.sv | 37 +++
 rtl/sync_ram_bot.sv | 24 ++
 rtl/jogador_automatico.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/jogador_pkg.sv
// Shared state encodings, parameter defaults and helpers for the auto-player bot.
package jogador_pkg;

  localparam int unsigned DEPTH_PADRAO = 16;
  localparam int unsigned PRESS_PADRAO = 4;
  localparam int unsigned GAP_PADRAO   = 4;
  localparam int unsigned IDLE_PADRAO  = 8;

  localparam int unsigned LED_W     = 4;
  localparam int unsigned ESTADO_W  = 4;
  localparam int unsigned TAMANHO_W = 5;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL      = 4'd0,
    ESPERA_LED   = 4'd1,
    REGISTRA     = 4'd2,
    ESPERA_APAGA = 4'd3,
    PRESSIONA    = 4'd4,
    SOLTA        = 4'd5,
    PROXIMA      = 4'd6,
    FIM          = 4'd7
  } estado_t;

  // True when exactly one bit of the led pattern is set.
  function automatic logic one_hot(input logic [LED_W-1:0] v);
    return (v != '0) && ((v & (v - LED_W'(1))) == '0);
  endfunction

  // Largest of three cycle counts, used to size the shared timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ram_bot.sv
// Move buffer: synchronous write, combinational read, no reset on storage.
module sync_ram_bot #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/jogador_automatico.sv
// Auto-player: records one-hot led moves, then replays them as timed button presses.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int unsigned DEPTH        = DEPTH_PADRAO,
  parameter int unsigned PRESS_CYCLES = PRESS_PADRAO,
  parameter int unsigned GAP_CYCLES   = GAP_PADRAO,
  parameter int unsigned IDLE_TIMEOUT = IDLE_PADRAO
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 habilitar,
  input  logic [LED_W-1:0]     leds,
  output logic [LED_W-1:0]     botoes,
  output logic                 ocupado,
  output logic                 pronto,
  output logic                 erro_padrao,
  output logic [ESTADO_W-1:0]  db_estado,
  output logic [TAMANHO_W-1:0] db_tamanho
);

  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TMAX = max3(PRESS_CYCLES, GAP_CYCLES, IDLE_TIMEOUT);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  estado_t          estado_q, estado_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             erro_q, erro_d;
  logic [LED_W-1:0] botoes_q;
  logic             pronto_q, ocupado_q;
  logic             ram_we;
  logic [LED_W-1:0] ram_rdata;

  sync_ram_bot #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (LED_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (AW'(count_q)),
    .wdata (led_q),
    .raddr (idx_d),
    .rdata (ram_rdata)
  );

  // State register and registered outputs, looked ahead from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      count_q   <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      led_q     <= '0;
      erro_q    <= 1'b0;
      botoes_q  <= '0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
      erro_q    <= erro_d;
      botoes_q  <= (estado_d == PRESSIONA) ? ram_rdata : '0;
      pronto_q  <= (estado_d == FIM);
      ocupado_q <= (estado_d != INICIAL);
    end
  end

  // Next-state logic: record phase, idle timeout, replay phase.
  always_comb begin
    estado_d = estado_q;
    count_d  = count_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    led_d    = led_q;
    erro_d   = erro_q;
    ram_we   = 1'b0;

    case (estado_q)
      INICIAL: begin
        if (habilitar) begin
          estado_d = ESPERA_LED;
          count_d  = '0;
          idx_d    = '0;
          timer_d  = '0;
        end
      end
      ESPERA_LED: begin
        if (one_hot(leds)) begin
          if (count_q == CW'(DEPTH)) begin
            // Buffer full: flag it and wait for the led to go dark.
            erro_d   = 1'b1;
            estado_d = ESPERA_APAGA;
          end else begin
            led_d    = leds;
            estado_d = REGISTRA;
          end
        end else if (leds != '0) begin
          erro_d   = 1'b1;
          estado_d = ESPERA_APAGA;
        end else if (count_q != '0) begin
          if (timer_q == TW'(IDLE_TIMEOUT - 1)) begin
            estado_d = PRESSIONA;
            idx_d    = '0;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      REGISTRA: begin
        ram_we   = 1'b1;
        count_d  = count_q + CW'(1);
        estado_d = ESPERA_APAGA;
      end
      ESPERA_APAGA: begin
        if (leds == '0) begin
          timer_d  = '0;
          estado_d = ESPERA_LED;
        end
      end
      PRESSIONA: begin
        if (timer_q == TW'(PRESS_CYCLES - 1)) begin
          timer_d  = '0;
          estado_d = SOLTA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SOLTA: begin
        if (timer_q == TW'(GAP_CYCLES - 1)) begin
          timer_d  = '0;
          estado_d = PROXIMA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PROXIMA: begin
        idx_d    = idx_q + AW'(1);
        estado_d = ((CW'(idx_q) + CW'(1)) == count_q) ? FIM : PRESSIONA;
      end
      FIM: begin
        count_d  = '0;
        timer_d  = '0;
        estado_d = ESPERA_LED;
      end
      default: estado_d = INICIAL;
    endcase

    if (!habilitar) estado_d = INICIAL;
    if (estado_d == INICIAL) erro_d = 1'b0;
  end

  assign botoes      = botoes_q;
  assign pronto      = pronto_q;
  assign ocupado     = ocupado_q;
  assign erro_padrao = erro_q;
  assign db_estado   = estado_q;
  assign db_tamanho  = TAMANHO_W'(count_q);

endmodule
